// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: instruction layout, opcodes, register-file geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Register file geometry
  localparam int NREGS  = 16;
  localparam int REG_AW = $clog2(NREGS);
  localparam int XLEN   = 32;

  // Instruction field bit positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int RD_MSB   = 27;
  localparam int RD_LSB   = 24;
  localparam int RS1_MSB  = 23;
  localparam int RS1_LSB  = 20;
  localparam int RS2_MSB  = 19;
  localparam int RS2_LSB  = 16;
  localparam int SH_MSB   = 15;
  localparam int SH_LSB   = 11;
  localparam int USEI_BIT = 10;
  localparam int IMM_MSB  = 9;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

  // Opcodes understood by the downstream alu
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SHL = 4'h5,
    OP_SHR = 4'h6,
    OP_SRA = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_MUL = 4'hA,
    OP_MULU = 4'hB
  } alu_op_e;

  // Decoded view of a 32-bit instruction word; field order matches the bit positions above
  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [4:0]        r;
    logic              use_imm;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  // One scoreboard entry: a destination register with a result still in flight
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
  } sb_slot_t;

  // Zero-extend the 10-bit immediate to a full operand
  function automatic logic [XLEN-1:0] imm_zext(input logic [IMM_W-1:0] imm);
    return {{(XLEN - IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: 2 operand read ports, 1 writeback port, 1 debug read port; r0 reads 0.
// Latency: reads are combinational, a write is visible the cycle after it is presented.
// Backpressure: none, every write is taken.
module alu_regfile #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1_i,
  output logic [DW-1:0] rd1_o,
  input  logic [AW-1:0] ra2_i,
  output logic [DW-1:0] rd2_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] mem_q [NREGS];

  // Storage: cleared on reset, writes to r0 dropped so it stays zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Read ports: r0 forced to zero independent of storage contents
  always_comb begin
    rd1_o      = (ra1_i == '0)      ? '0 : mem_q[ra1_i];
    rd2_o      = (ra2_i == '0)      ? '0 : mem_q[ra2_i];
    dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage feeding the alu: decode, register read, scoreboard and writeback of the 64-bit result.
// Latency: accept in N, alu_* valid in N+1, result sampled end of N+1+ALU_LAT, readable from N+2+ALU_LAT.
// Backpressure: instr_ready drops while a source register has a result in flight (RAW); no forwarding.
module alu_operand_stage #(
  parameter int ALU_LAT = 1,
  parameter int NREGS   = alu_pkg::NREGS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_r,
  output logic [3:0]  alu_opcode,
  output logic        alu_issue,
  input  logic [63:0] alu_out,
  output logic [31:0] hi_out,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  import alu_pkg::*;

  localparam int NSLOT = ALU_LAT + 1;

  instr_t      dec;
  logic        hazard;
  logic        accept;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;

  sb_slot_t    slot_q [NSLOT];
  sb_slot_t    slot_d [NSLOT];
  sb_slot_t    wb;

  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_r_q, alu_r_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic        issue_q, issue_d;
  logic [31:0] hi_q, hi_d;

  // Decode straight from the bus; hazard check runs even when instr_valid is low
  assign dec = instr_t'(instr);

  // RAW check: any in-flight non-zero destination matching a source actually used
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_q[i].vld && (slot_q[i].rd != '0)) begin
        if (slot_q[i].rd == dec.rs1) begin
          hazard = 1'b1;
        end
        if (!dec.use_imm && (slot_q[i].rd == dec.rs2)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign instr_ready = !hazard;
  assign accept      = instr_valid && instr_ready;

  // Oldest scoreboard slot lines up with the cycle alu_out is valid
  assign wb = slot_q[NSLOT-1];

  alu_regfile #(
    .NREGS (NREGS),
    .AW    (REG_AW),
    .DW    (XLEN)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra1_i      (dec.rs1),
    .rd1_o      (rf_rs1),
    .ra2_i      (dec.rs2),
    .rd2_o      (rf_rs2),
    .we_i       (wb.vld),
    .wa_i       (wb.rd),
    .wd_i       (alu_out[31:0]),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Scoreboard shift: new entry on accept, everything moves one slot per cycle
  always_comb begin
    slot_d[0].vld = accept;
    slot_d[0].rd  = dec.rd;
    for (int i = 1; i < NSLOT; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  // Scoreboard register: reset drops every in-flight result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Issue registers hold the last operation until the next accept; HI follows every writeback
  always_comb begin
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_r_d  = alu_r_q;
    alu_op_d = alu_op_q;
    issue_d  = accept;
    hi_d     = wb.vld ? alu_out[63:32] : hi_q;
    if (accept) begin
      alu_a_d  = rf_rs1;
      alu_b_d  = dec.use_imm ? imm_zext(dec.imm) : rf_rs2;
      alu_r_d  = dec.r;
      alu_op_d = dec.opcode;
    end
  end

  // Issue and HI state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_r_q  <= '0;
      alu_op_q <= '0;
      issue_q  <= 1'b0;
      hi_q     <= '0;
    end else begin
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_r_q  <= alu_r_d;
      alu_op_q <= alu_op_d;
      issue_q  <= issue_d;
      hi_q     <= hi_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_r      = alu_r_q;
  assign alu_opcode = alu_op_q;
  assign alu_issue  = issue_q;
  assign hi_out     = hi_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with ALU_LAT = 1.
// Latency: a stub ALU returns queued results one cycle after each alu_issue.
// Backpressure: the bench holds instr_valid/instr across stalls like a real producer.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_r;
  logic [3:0]  alu_opcode;
  logic        alu_issue;
  logic [63:0] alu_out;
  logic [31:0] hi_out;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] res_q [$];

  alu_operand_stage #(.ALU_LAT(1), .NREGS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_r       (alu_r),
    .alu_opcode  (alu_opcode),
    .alu_issue   (alu_issue),
    .alu_out     (alu_out),
    .hi_out      (hi_out),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: one cycle after an issue, present the next queued result
  always @(posedge clk) begin
    if (alu_issue && (res_q.size() > 0)) begin
      #1;
      alu_out = res_q.pop_front();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] res;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_r;
    logic [3:0]  exp_op;
    logic [3:0]  rd;
    logic [31:0] exp_rd;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [4:0] r, input logic ui,
                                      input logic [9:0] imm);
    return {op, rd, rs1, rs2, r, ui, imm};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    res_q.push_back(v.res);
    instr       = v.instr;
    instr_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), instr_ready, 1'b1);
    next_cycle();
    instr_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_issue", idx), alu_issue, 1'b1);
    chk($sformatf("v%0d_a", idx), alu_a, v.exp_a);
    chk($sformatf("v%0d_b", idx), alu_b, v.exp_b);
    chk($sformatf("v%0d_r", idx), alu_r, v.exp_r);
    chk($sformatf("v%0d_op", idx), alu_opcode, v.exp_op);
    next_cycle();
    next_cycle();
    dbg_addr = v.rd;
    @(negedge clk);
    chk($sformatf("v%0d_rd", idx), dbg_data, v.exp_rd);
    chk($sformatf("v%0d_hi", idx), hi_out, v.exp_hi);
    next_cycle();
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    alu_out     = '0;
    dbg_addr    = '0;

    vecs[0] = '{enc(4'd0, 4'd1, 4'd0, 4'd0, 5'd0, 1'b1, 10'd30), 64'h0000_0005_0000_001E,
                32'd0, 32'd30, 5'd0, 4'd0, 4'd1, 32'd30, 32'd5};
    vecs[1] = '{enc(4'd0, 4'd2, 4'd0, 4'd0, 5'd0, 1'b1, 10'd11), 64'h0000_0000_0000_000B,
                32'd0, 32'd11, 5'd0, 4'd0, 4'd2, 32'd11, 32'd0};
    vecs[2] = '{enc(4'd2, 4'd7, 4'd1, 4'd2, 5'd3, 1'b0, 10'd0), 64'hAAAA_0000_0000_0029,
                32'd30, 32'd11, 5'd3, 4'd2, 4'd7, 32'h29, 32'hAAAA_0000};
    vecs[3] = '{enc(4'd5, 4'd10, 4'd7, 4'd0, 5'd31, 1'b1, 10'h3FF), 64'h0000_0001_FFFF_FFFF,
                32'h29, 32'h3FF, 5'd31, 4'd5, 4'd10, 32'hFFFF_FFFF, 32'd1};

    // Reset: 3 cycles low, then release
    repeat (3) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_issue", alu_issue, 1'b0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    for (int a = 0; a < 16; a++) begin
      dbg_addr = a[3:0];
      #1;
      chk($sformatf("rst_reg%0d", a), dbg_data, 32'd0);
    end
    next_cycle();

    // Table: independent single issues, each run to writeback
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], i);
    end

    // RAW stall: rd2 <- 20, then dependent rs1=2, rs2=1
    res_q.push_back(64'h0000_0000_0000_0014);
    instr       = enc(4'd0, 4'd2, 4'd0, 4'd0, 5'd0, 1'b1, 10'd20);
    instr_valid = 1'b1;
    @(negedge clk);
    chk("raw_prod_ready", instr_ready, 1'b1);
    next_cycle();                                   // N+1
    res_q.push_back(64'h0000_0000_0000_0032);
    instr = enc(4'd1, 4'd8, 4'd2, 4'd1, 5'd0, 1'b0, 10'd0);
    @(negedge clk);
    chk("raw_ready_n1", instr_ready, 1'b0);
    chk("raw_prod_b", alu_b, 32'd20);
    next_cycle();                                   // N+2
    @(negedge clk);
    chk("raw_ready_n2", instr_ready, 1'b0);
    chk("raw_issue_n2", alu_issue, 1'b0);
    next_cycle();                                   // N+3
    @(negedge clk);
    chk("raw_ready_n3", instr_ready, 1'b1);
    next_cycle();                                   // N+4
    instr_valid = 1'b0;
    @(negedge clk);
    chk("raw_issue", alu_issue, 1'b1);
    chk("raw_a", alu_a, 32'd20);
    chk("raw_b", alu_b, 32'd30);
    chk("raw_op", alu_opcode, 4'd1);
    next_cycle();
    next_cycle();                                   // N+6
    dbg_addr = 4'd8;
    @(negedge clk);
    chk("raw_reg8", dbg_data, 32'h32);
    next_cycle();

    // Back-to-back: four immediates to r3..r6
    for (int i = 0; i < 4; i++) begin
      res_q.push_back({32'(i + 1), 32'(1000 + i)});
    end
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = enc(4'd0, 4'(3 + i), 4'd0, 4'd0, 5'd0, 1'b1, 10'(100 + i));
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", i), instr_ready, 1'b1);
      if (i > 0) begin
        chk($sformatf("b2b_issue%0d", i - 1), alu_issue, 1'b1);
        chk($sformatf("b2b_b%0d", i - 1), alu_b, 32'(100 + i - 1));
      end
      next_cycle();
    end
    instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_issue3", alu_issue, 1'b1);
    chk("b2b_b3", alu_b, 32'd103);
    next_cycle();
    @(negedge clk);
    chk("b2b_issue_end", alu_issue, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 4'(3 + i);
      #1;
      chk($sformatf("b2b_reg%0d", 3 + i), dbg_data, 32'(1000 + i));
    end
    chk("b2b_hi", hi_out, 32'd4);
    next_cycle();

    // rd = 0: result discarded, HI still updated, reader of r0 not stalled
    res_q.push_back(64'h0000_0007_0000_0009);
    instr       = enc(4'd3, 4'd0, 4'd7, 4'd0, 5'd0, 1'b1, 10'd5);
    instr_valid = 1'b1;
    @(negedge clk);
    chk("r0_ready", instr_ready, 1'b1);
    next_cycle();                                   // N+1
    res_q.push_back(64'h0000_0000_0000_1234);
    instr = enc(4'd0, 4'd9, 4'd0, 4'd0, 5'd0, 1'b0, 10'd0);
    @(negedge clk);
    chk("r0_nostall", instr_ready, 1'b1);
    chk("r0_a", alu_a, 32'h29);
    chk("r0_b", alu_b, 32'd5);
    next_cycle();                                   // N+2
    instr_valid = 1'b0;
    @(negedge clk);
    chk("r0_rd_issue", alu_issue, 1'b1);
    chk("r0_rd_a", alu_a, 32'd0);
    next_cycle();                                   // N+3
    dbg_addr = 4'd0;
    @(negedge clk);
    chk("r0_reg0", dbg_data, 32'd0);
    chk("r0_hi", hi_out, 32'd7);
    next_cycle();                                   // N+4
    dbg_addr = 4'd9;
    @(negedge clk);
    chk("r0_reg9", dbg_data, 32'h1234);
    chk("r0_hi_after", hi_out, 32'd0);
    next_cycle();

    // Reset mid-flight: accept rd4, reset the next cycle
    res_q.push_back(64'h0000_00EE_0000_004D);
    instr       = enc(4'd0, 4'd4, 4'd0, 4'd0, 5'd0, 1'b1, 10'd77);
    instr_valid = 1'b1;
    next_cycle();                                   // N+1
    instr_valid = 1'b0;
    instr       = enc(4'd0, 4'd11, 4'd4, 4'd4, 5'd0, 1'b0, 10'd0);
    rst_n       = 1'b0;
    next_cycle();                                   // N+2
    next_cycle();                                   // N+3
    rst_n = 1'b1;
    res_q.delete();
    dbg_addr = 4'd4;
    @(negedge clk);
    chk("mid_ready", instr_ready, 1'b1);
    chk("mid_issue", alu_issue, 1'b0);
    chk("mid_reg4", dbg_data, 32'd0);
    chk("mid_hi", hi_out, 32'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("mid_reg4_late", dbg_data, 32'd0);
    chk("mid_ready_late", instr_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Issue stage directly upstream of the `alu` execute unit. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads operands from a 16×32 register file and drives the ALU's `a`, `b`, `r` and `opcode` inputs. It then captures the ALU's 64-bit result after a fixed latency and writes it back: the low word goes to the destination register and the high word to a HI register. A scoreboard stalls intake on read-after-write hazards; there is no forwarding.

## Interface
- `ALU_LAT`, default 1: cycles from `alu_issue` to a valid `alu_out`. Range 1–4.
- `NREGS`, default 16: number of architectural registers. r0 reads as 0.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  `instr` holds a valid instruction.
- `instr`  in  32  instruction word.
- `instr_ready`  out  1  stage can accept an instruction this cycle.
- `alu_a`  out  32  operand A, driven to ALU `a`.
- `alu_b`  out  32  operand B, driven to ALU `b`.
- `alu_r`  out  5  shift/rotate amount, driven to ALU `r`.
- `alu_opcode`  out  4  driven to ALU `opcode`.
- `alu_issue`  out  1  one-cycle pulse: `alu_*` outputs hold a new operation.
- `alu_out`  in  64  result from the ALU.
- `hi_out`  out  32  HI register, holding the upper result word of the last writeback.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  32  combinational read of `regfile[dbg_addr]`.

## Operation
- Instruction field decode:
  - [31:28] opcode
  - [27:24] rd
  - [23:20] rs1
  - [19:16] rs2
  - [15:11] r
  - [10] use_imm
  - [9:0] imm, zero-extended to 32 bits
- Operand selection:
  - `alu_a` = reg[rs1].
  - `alu_b` = use_imm ? imm : reg[rs2].
  - `alu_opcode` and `alu_r` pass through unmodified.
- Accept condition: a transfer occurs when `instr_valid && instr_ready`. Operands are read from the register file in the accept cycle and registered.
- Scoreboard:
  - A shift pipeline of `ALU_LAT+1` slots holds {valid, rd}.
  - A slot is loaded on accept and advances every cycle. The oldest slot performs the writeback.
- Hazard stall:
  - `instr_ready` = 0 while any valid slot has rd ≠ 0 and rd equal to the decoded rs1.
  - The same applies for rs2 when use_imm = 0.
  - The decode is taken from `instr` regardless of `instr_valid`. A stalled instruction is held by the producer.
- Writeback (when the oldest slot is valid):
  - reg[rd] ← `alu_out[31:0]`, skipped if rd = 0.
  - `hi_out` ← `alu_out[63:32]`. HI updates even when rd = 0.
- Throughput: there is no structural stall, so independent instructions issue one per cycle.
- Reset:
  - Clears the register file, HI, every scoreboard slot, `alu_*` outputs and `alu_issue`.
  - Results in flight are discarded.
  - `instr_ready` = 1 in the first cycle after reset is deasserted.

## Timing
- Accept in cycle N.
- `alu_a/b/r/opcode` are valid and `alu_issue` = 1 in cycle N+1. These outputs hold their values until the next issue.
- `alu_out` is sampled at the end of cycle N+1+ALU_LAT. The written value is visible on `dbg_data` and to operand reads from cycle N+2+ALU_LAT.
- Dependent instruction presented at N+1: `instr_ready` rises in cycle N+2+ALU_LAT. The minimum dependent spacing is ALU_LAT+2 cycles.
- Simultaneous writeback and read of the same register cannot occur, because the scoreboard blocks it.
- A writeback to an unrelated register in the accept cycle does not disturb the read.

## Structure
- Shared package `alu_pkg` holds:
  - instruction field bit positions,
  - opcode constants shared with `alu`,
  - `NREGS` and the register-address width.
- Sub-module `alu_regfile`: 16×32 storage with 2 read ports, 1 write port and 1 debug read port. r0 is hard-wired to 0.
- The scoreboard, decode and issue registers live in the top module.

## Test plan
All scenarios use `ALU_LAT` = 1.

1. **Reset:** hold `rst_n` = 0 for 3 cycles, then release.
   - Required: `instr_ready` = 1, `alu_issue` = 0, `hi_out` = 0, `dbg_data` = 0 for every address.
2. **Immediate issue:** accept opcode 0, rd = 1, rs1 = 0, use_imm = 1, imm = 30 in cycle N.
   - Required: cycle N+1 has `alu_a` = 0, `alu_b` = 30, `alu_issue` = 1.
   - Drive `alu_out` = 64'h0000_0005_0000_001E in cycle N+2.
   - Required: from N+3, reg1 = 30 and `hi_out` = 5.
3. **RAW stall:** accept rd = 2 with imm 20 in cycle N, then present rs1 = 2, rs2 = 1, opcode 1 at N+1.
   - Required: `instr_ready` = 0 in N+1 and N+2, and 1 in N+3.
   - Required: the issued instruction has `alu_a` = 20 and `alu_b` = 30.
4. **Back-to-back independent:** four immediate instructions to rd = 3..6.
   - Required: `alu_issue` is high 4 consecutive cycles with no `instr_ready` drop, and each register gets its result.
5. **rd = 0 discard:** an instruction with rd = 0 and result 64'h0000_0007_0000_0009.
   - Required: reg0 still reads 0, `hi_out` = 7, and a following instruction reading r0 does not stall.
6. **Reset mid-flight:** assert `rst_n` = 0 in the cycle after an accept with rd = 4.
   - Required: reg4 stays 0, all scoreboard slots are cleared, and `instr_ready` = 1 after release.
